// File: rtl/operand_display_controller.sv
// operand_display_controller: two operand registers, an 8-way ALU, a sequential
// shift-add-3 binary-to-BCD converter and active-low seven-segment drivers.

// Active-low seven-segment encoder for one BCD digit (bit order g..a).
module odc_seg7 (
  input  logic [3:0] d,
  input  logic       blank,
  output logic [6:0] seg
);
  // Decimal digit to segment pattern; non-decimal codes and blanked digits are dark.
  always_comb begin
    seg = 7'b1111111;
    if (!blank) begin
      case (d)
        4'd0: seg = 7'b1000000;
        4'd1: seg = 7'b1111001;
        4'd2: seg = 7'b0100100;
        4'd3: seg = 7'b0110000;
        4'd4: seg = 7'b0011001;
        4'd5: seg = 7'b0010010;
        4'd6: seg = 7'b0000010;
        4'd7: seg = 7'b1111000;
        4'd8: seg = 7'b0000000;
        4'd9: seg = 7'b0010000;
        default: seg = 7'b1111111;
      endcase
    end
  end
endmodule

module operand_display_controller #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      Ain,
  input  logic [WIDTH-1:0]      Bin,
  input  logic                  Sel,
  input  logic                  E,
  input  logic [2:0]            Operation,
  output logic [WIDTH-1:0]      A,
  output logic [WIDTH-1:0]      B,
  output logic                  Busy,
  output logic                  Valid,
  output logic                  Neg,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   HEX,
  output logic [6:0]            HEXSign
);
  localparam int R  = WIDTH + 1;
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(R + 1);

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // The display must be able to hold the largest R-bit result.
  if (pow10(DIGITS) <= ((longint'(1) << R) - 1)) begin : g_range_err
    $error("operand_display_controller: DIGITS too small for WIDTH");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state;
  logic [R-1:0]  val, last_val, bin;
  logic          sgn, last_sgn;
  logic [BW-1:0] work, adj, work_nxt;
  logic [CW-1:0] cnt;

  // Operand registers: one operand per edge, chosen by Sel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      A <= '0;
      B <= '0;
    end else if (E) begin
      if (!Sel) A <= Ain;
      else      B <= Bin;
    end
  end

  // ALU: R-bit magnitude plus sign; only the subtract reports a sign.
  always_comb begin
    val = '0;
    sgn = 1'b0;
    case (Operation)
      3'd0: val = {1'b0, A};
      3'd1: val = {1'b0, B};
      3'd2: val = {1'b0, A} + {1'b0, B};
      3'd3: val = {1'b0, A ^ B};
      3'd4: begin
        sgn = (A < B);
        val = sgn ? {1'b0, B - A} : {1'b0, A - B};
      end
      3'd5: val = {1'b0, A & B};
      3'd6: val = {1'b0, A | B};
      3'd7: val = (A > B) ? {1'b0, A} : {1'b0, B};
      default: val = '0;
    endcase
  end

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    assign adj[4*i +: 4] = (work[4*i +: 4] >= 4'd5) ? work[4*i +: 4] + 4'd3
                                                    : work[4*i +: 4];
  end

  assign work_nxt = {adj[BW-2:0], bin[R-1]};

  // Conversion FSM: start when the ALU result differs from the last one
  // converted, run R shifts, then publish bcd/Neg with a one-cycle Valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      Busy     <= 1'b0;
      Valid    <= 1'b0;
      Neg      <= 1'b0;
      bcd      <= '0;
      last_val <= '0;
      last_sgn <= 1'b0;
      bin      <= '0;
      work     <= '0;
      cnt      <= '0;
    end else begin
      Valid <= 1'b0;
      case (state)
        IDLE: begin
          if ({val, sgn} != {last_val, last_sgn}) begin
            bin      <= val;
            work     <= '0;
            last_val <= val;
            last_sgn <= sgn;
            cnt      <= '0;
            Busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          work <= work_nxt;
          bin  <= {bin[R-2:0], 1'b0};
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(R - 1)) begin
            bcd   <= work_nxt;
            Neg   <= last_sgn;
            Valid <= 1'b1;
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Leading-zero blanking: digit i>0 is dark when it and all higher digits are 0.
  logic [DIGITS-1:0] blank;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    if (i == 0) begin : g_lsd
      assign blank[i] = 1'b0;
    end else begin : g_hi
      assign blank[i] = ~|bcd[BW-1:4*i];
    end
    odc_seg7 u_seg (
      .d     (bcd[4*i +: 4]),
      .blank (blank[i]),
      .seg   (HEX[7*i +: 7])
    );
  end

  assign HEXSign = Neg ? 7'b0111111 : 7'b1111111;

endmodule
